// File: rtl/mcpu_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_pkg
// Shared definitions for the multi-cycle CPU controller:
//   - state encodings (state_t), including the optional ADDI states
//   - instruction opcode constants (instruction register bits [31:26])
//   - select codes for alu_src_b, pc_src and alu_op
// Configuration macro: MCPU_ADDI_EN adds the ADDIEX/ADDIWB states.
// -----------------------------------------------------------------------------
package mcpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BEQ    = 4'd9,
        ST_JUMP   = 4'd10,
`ifdef MCPU_ADDI_EN
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12,
`endif
        ST_HALT   = 4'd15
    } state_t;

    // Opcodes (instruction register bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select (2'b11 is reserved and never driven)
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU control (2'b11 is reserved)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for states that retire an instruction
    function automatic logic is_final_state(input state_t st);
        logic fin;
        case (st)
            ST_MEMWB, ST_MEMWR, ST_RWB, ST_BEQ, ST_JUMP: fin = 1'b1;
`ifdef MCPU_ADDI_EN
            ST_ADDIWB:                                   fin = 1'b1;
`endif
            default:                                     fin = 1'b0;
        endcase
        return fin;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl_dec
// Pure combinational Moore decode: state register value -> datapath strobes
// and select codes. Unknown/unused encodings decode to all-zero (safe) outputs.
// Ports:
//   state      in  4   current FSM state
//   iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg, reg_wr, alu_src_a  out 1
//   alu_src_b, pc_src, alu_op                                          out 2
//   pc_wr, pc_wr_cond                                                  out 1
//   halted                                                             out 1
// Configuration macro: MCPU_ADDI_EN decodes the ADDIEX/ADDIWB states.
// -----------------------------------------------------------------------------
module mcpu_ctrl_dec
    import mcpu_pkg::*;
(
    input  logic [3:0] state,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       reg_wr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       pc_wr,
    output logic       pc_wr_cond,
    output logic       halted
);

    // State-to-output decode with everything defaulted inactive
    always_comb begin
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        reg_wr     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        alu_op     = ALUOP_ADD;
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_IDLE: begin
                halted = 1'b0;
            end
            ST_FETCH: begin
                mem_rd    = 1'b1;
                ir_wr     = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_wr     = 1'b1;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMMSH;
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            ST_MEMWB: begin
                reg_wr  = 1'b1;
                mem2reg = 1'b1;
            end
            ST_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUB;
                pc_wr_cond = 1'b1;
                pc_src     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = PCSRC_JUMP;
            end
`ifdef MCPU_ADDI_EN
            ST_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_ADDIWB: begin
                reg_wr = 1'b1;
            end
`endif
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl
// Multi-cycle CPU control unit (Moore FSM). Holds the state register and the
// retired-instruction counter; output decode lives in mcpu_ctrl_dec.
// Ports:
//   clk        in  1       rising-edge clock
//   rst_n      in  1       asynchronous active-low reset
//   run        in  1       start/continue; sampled in IDLE and at instruction end
//   opcode     in  6       instruction register bits [31:26]
//   zero       in  1       ALU zero flag (only affects pc_we, combinationally)
//   iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg, reg_wr, alu_src_a  out 1
//   alu_src_b, pc_src, alu_op                                          out 2
//   pc_we      out 1       pc_wr | (pc_wr_cond & zero)
//   state      out 4       current state (debug)
//   halted     out 1       sticky HALT indication (debug)
//   icnt       out ICNT_W  retired instruction count, wraps (debug)
// Configuration macro: MCPU_ADDI_EN enables the ADDI instruction (opcode
// 001000); without it that opcode halts the controller.
// -----------------------------------------------------------------------------
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int ICNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [5:0]        opcode,
    input  logic              zero,
    output logic              iord,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              ir_wr,
    output logic              reg_dst,
    output logic              mem2reg,
    output logic              reg_wr,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        pc_src,
    output logic [1:0]        alu_op,
    output logic              pc_we,
    output logic [3:0]        state,
    output logic              halted,
    output logic [ICNT_W-1:0] icnt
);

    localparam logic [ICNT_W-1:0] ICNT_ONE = {{(ICNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ICNT_W-1:0] icnt_r;
    logic              instr_done_s;
    logic              pc_wr_s;
    logic              pc_wr_cond_s;

    assign instr_done_s = is_final_state(state_r);

    // Next-state logic; run is only honoured in IDLE and at instruction end
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt_s = ST_MEMADR;
                    OP_RTYPE:     state_nxt_s = ST_EXEC;
                    OP_BEQ:       state_nxt_s = ST_BEQ;
                    OP_J:         state_nxt_s = ST_JUMP;
`ifdef MCPU_ADDI_EN
                    OP_ADDI:      state_nxt_s = ST_ADDIEX;
`endif
                    default:      state_nxt_s = ST_HALT;
                endcase
            end
            ST_MEMADR: begin
                // Only lw/sw reach here; opcode is stable for the instruction
                if (opcode == OP_SW) begin
                    state_nxt_s = ST_MEMWR;
                end else begin
                    state_nxt_s = ST_MEMRD;
                end
            end
            ST_MEMRD: begin
                state_nxt_s = ST_MEMWB;
            end
            ST_EXEC: begin
                state_nxt_s = ST_RWB;
            end
`ifdef MCPU_ADDI_EN
            ST_ADDIEX: begin
                state_nxt_s = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`endif
            ST_MEMWB, ST_MEMWR, ST_RWB, ST_BEQ, ST_JUMP: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                // Corrupted/unused encoding: park safely in HALT
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Retired instruction counter, bumped on the last cycle of each instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_r <= {ICNT_W{1'b0}};
        end else if (instr_done_s) begin
            icnt_r <= icnt_r + ICNT_ONE;
        end else begin
            icnt_r <= icnt_r;
        end
    end

    mcpu_ctrl_dec u_dec (
        .state      (state_r),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_wr      (ir_wr),
        .reg_dst    (reg_dst),
        .mem2reg    (mem2reg),
        .reg_wr     (reg_wr),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .pc_wr      (pc_wr_s),
        .pc_wr_cond (pc_wr_cond_s),
        .halted     (halted)
    );

    // pc_we is the only output that depends on an input (zero) directly
    assign pc_we = pc_wr_s | (pc_wr_cond_s & zero);
    assign state = state_r;
    assign icnt  = icnt_r;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mcpu_ctrl
// Directed self-checking bench for mcpu_ctrl. Inputs change and outputs are
// sampled on the falling clock edge. Output vector layout (15 bits):
//   {iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg, reg_wr, alu_src_a,
//    alu_src_b[1:0], pc_src[1:0], alu_op[1:0], pc_we}
// -----------------------------------------------------------------------------
module tb_mcpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic        zero;
    logic        iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg, reg_wr, alu_src_a;
    logic [1:0]  alu_src_b, pc_src, alu_op;
    logic        pc_we;
    logic [3:0]  state;
    logic        halted;
    logic [31:0] icnt;
    logic [14:0] outs;

    int total;
    int bad;
    int exp_icnt;

    // Hand-computed expected output vectors per state
    localparam logic [14:0] O_ZERO   = 15'b00000000_000000_0;
    localparam logic [14:0] O_FETCH  = 15'b01010000_010000_1;
    localparam logic [14:0] O_DECODE = 15'b00000000_110000_0;
    localparam logic [14:0] O_MEMADR = 15'b00000001_100000_0;
    localparam logic [14:0] O_MEMRD  = 15'b11000000_000000_0;
    localparam logic [14:0] O_MEMWB  = 15'b00000110_000000_0;
    localparam logic [14:0] O_MEMWR  = 15'b10100000_000000_0;
    localparam logic [14:0] O_EXEC   = 15'b00000001_000010_0;
    localparam logic [14:0] O_RWB    = 15'b00001010_000000_0;
    localparam logic [14:0] O_BEQ_T  = 15'b00000001_000101_1;
    localparam logic [14:0] O_BEQ_F  = 15'b00000001_000101_0;
    localparam logic [14:0] O_JUMP   = 15'b00000000_001000_1;
    localparam logic [14:0] O_ADDIEX = 15'b00000001_100000_0;
    localparam logic [14:0] O_ADDIWB = 15'b00000010_000000_0;

    assign outs = {iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg, reg_wr, alu_src_a,
                   alu_src_b, pc_src, alu_op, pc_we};

    mcpu_ctrl #(.ICNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .opcode    (opcode),
        .zero      (zero),
        .iord      (iord),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_wr     (ir_wr),
        .reg_dst   (reg_dst),
        .mem2reg   (mem2reg),
        .reg_wr    (reg_wr),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .pc_we     (pc_we),
        .state     (state),
        .halted    (halted),
        .icnt      (icnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check state number and the full output vector at once
    task automatic chk_st(input string tag, input logic [3:0] st, input logic [14:0] o);
        chk({tag, ".state"}, 64'(state), 64'(st));
        chk({tag, ".outs"},  64'(outs),  64'(o));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_icnt = 0;
        rst_n    = 1'b0;
        run      = 1'b0;
        opcode   = 6'b100011;
        zero     = 1'b0;

        // Reset state, before any clock edge
        #1;
        chk_st("reset", 4'd0, O_ZERO);
        chk("reset.icnt", 64'(icnt), 64'd0);
        chk("reset.halted", 64'(halted), 64'd0);

        // lw: 1,2,3,4,5 then back to FETCH with icnt=1
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        step(); chk_st("lw.fetch", 4'd1, O_FETCH);
        step(); chk_st("lw.decode", 4'd2, O_DECODE);
        step(); chk_st("lw.memadr", 4'd3, O_MEMADR);
        step(); chk_st("lw.memrd", 4'd4, O_MEMRD);
        chk("lw.icnt_mid", 64'(icnt), 64'd0);
        step(); chk_st("lw.memwb", 4'd5, O_MEMWB);
        step(); chk_st("lw.fetch2", 4'd1, O_FETCH);
        exp_icnt = 1;
        chk("lw.icnt", 64'(icnt), 64'(exp_icnt));

        // beq taken (zero=1) and not-taken (zero=0), 3 cycles each
        opcode = 6'b000100;
        zero   = 1'b1;
        step(); chk_st("beqt.decode", 4'd2, O_DECODE);
        step(); chk_st("beqt.beq", 4'd9, O_BEQ_T);
        zero = 1'b0;
        #1;
        chk("beqt.pc_we_comb", 64'(pc_we), 64'd0);
        zero = 1'b1;
        step(); chk_st("beqt.fetch", 4'd1, O_FETCH);
        exp_icnt++;
        chk("beqt.icnt", 64'(icnt), 64'(exp_icnt));
        zero = 1'b0;
        step(); chk_st("beqf.decode", 4'd2, O_DECODE);
        step(); chk_st("beqf.beq", 4'd9, O_BEQ_F);
        step(); chk_st("beqf.fetch", 4'd1, O_FETCH);
        exp_icnt++;

        // j
        opcode = 6'b000010;
        step(); chk_st("j.decode", 4'd2, O_DECODE);
        step(); chk_st("j.jump", 4'd10, O_JUMP);
        step(); chk_st("j.fetch", 4'd1, O_FETCH);
        exp_icnt++;
        chk("j.icnt", 64'(icnt), 64'(exp_icnt));

        // sw
        opcode = 6'b101011;
        step(); chk_st("sw.decode", 4'd2, O_DECODE);
        step(); chk_st("sw.memadr", 4'd3, O_MEMADR);
        step(); chk_st("sw.memwr", 4'd6, O_MEMWR);
        step(); chk_st("sw.fetch", 4'd1, O_FETCH);
        exp_icnt++;

        // R-type with run dropped in EXEC: completes, then IDLE
        opcode = 6'b000000;
        step(); chk_st("r.decode", 4'd2, O_DECODE);
        step(); chk_st("r.exec", 4'd7, O_EXEC);
        run = 1'b0;
        step(); chk_st("r.rwb", 4'd8, O_RWB);
        step(); chk_st("r.idle", 4'd0, O_ZERO);
        exp_icnt++;
        chk("r.icnt", 64'(icnt), 64'(exp_icnt));
        step(); chk_st("r.idle_hold", 4'd0, O_ZERO);

        // addi: executes with the macro, halts without it
        opcode = 6'b001000;
        run    = 1'b1;
        step(); chk_st("addi.fetch", 4'd1, O_FETCH);
        step(); chk_st("addi.decode", 4'd2, O_DECODE);
        step();
`ifdef MCPU_ADDI_EN
        chk_st("addi.ex", 4'd11, O_ADDIEX);
        step(); chk_st("addi.wb", 4'd12, O_ADDIWB);
        step(); chk_st("addi.fetch2", 4'd1, O_FETCH);
        exp_icnt++;
        chk("addi.icnt", 64'(icnt), 64'(exp_icnt));
        // undefined opcode from FETCH
        opcode = 6'b111111;
        step(); chk_st("ill.decode", 4'd2, O_DECODE);
        step();
`else
        opcode = 6'b111111;
`endif
        chk_st("halt.enter", 4'd15, O_ZERO);
        chk("halt.halted", 64'(halted), 64'd1);
        for (int i = 0; i < 10; i++) begin
            zero = i[0];
            step();
            chk("halt.hold_state", 64'(state), 64'd15);
            chk("halt.hold_halted", 64'(halted), 64'd1);
            chk("halt.hold_outs", 64'(outs), 64'(O_ZERO));
        end
        chk("halt.icnt", 64'(icnt), 64'(exp_icnt));

        // rst_n pulse clears HALT
        rst_n = 1'b0;
        #1;
        chk_st("halt.rst", 4'd0, O_ZERO);
        chk("halt.rst_halted", 64'(halted), 64'd0);
        chk("halt.rst_icnt", 64'(icnt), 64'd0);
        #1;
        rst_n    = 1'b1;
        exp_icnt = 0;

        // Reset asynchronously mid-cycle in MEMRD
        opcode = 6'b100011;
        run    = 1'b1;
        step(); chk_st("rst2.fetch", 4'd1, O_FETCH);
        step(); chk_st("rst2.decode", 4'd2, O_DECODE);
        step(); chk_st("rst2.memadr", 4'd3, O_MEMADR);
        step(); chk_st("rst2.memrd", 4'd4, O_MEMRD);
        #1;
        rst_n = 1'b0;
        #1;
        chk_st("rst2.async", 4'd0, O_ZERO);
        chk("rst2.icnt", 64'(icnt), 64'd0);
        @(negedge clk);
        chk_st("rst2.held", 4'd0, O_ZERO);
        rst_n = 1'b1;
        step(); chk_st("rst2.refetch", 4'd1, O_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl.md
MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 SHALL have parameter ICNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  in  1  start/continue execution; sampled in IDLE and at instruction end.
REQ-005 SHALL have port opcode  in  6  instruction register bits [31:26].
REQ-006 SHALL have port zero  in  1  ALU zero flag.
REQ-007 SHALL have ports iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg, reg_wr, alu_src_a  out  1 each  multi-cycle datapath strobes/selects.
REQ-008 SHALL have ports alu_src_b, pc_src, alu_op  out  2 each  select codes for the downstream 32-bit 4-to-1 selectors and the ALU control.
REQ-009 SHALL have port pc_we  out  1  PC write enable = pc_wr OR (pc_wr_cond AND zero).
REQ-010 SHALL have ports state  out  4, halted  out  1, icnt  out  ICNT_W  debug visibility.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BEQ=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=15.
REQ-012 SHALL decode all outputs except pc_we from the state register only; pc_we is combinational in zero.
REQ-013 alu_src_b encoding SHALL be 00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-014 pc_src encoding SHALL be 00 ALU result, 01 ALUOut, 10 jump target, 11 reserved (never driven).
REQ-015 alu_op encoding SHALL be 00 add, 01 sub, 10 use funct, 11 reserved.
REQ-016 IDLE: all strobes 0, selects 00; go FETCH when run=1.
REQ-017 FETCH: mem_rd=1, ir_wr=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_wr=1; go DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 100011/101011 MEMADR, 000000 EXEC, 000100 BEQ, 000010 JUMP, 001000 ADDIEX (macro only), else HALT.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw to MEMRD, sw to MEMWR.
REQ-020 MEMRD: mem_rd=1, iord=1 -> MEMWB; MEMWB: reg_wr=1, mem2reg=1, reg_dst=0.
REQ-021 MEMWR: mem_wr=1, iord=1; EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB; RWB: reg_wr=1, reg_dst=1, mem2reg=0.
REQ-022 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_wr_cond=1, pc_src=01; JUMP: pc_wr=1, pc_src=10.
REQ-023 Final states (MEMWB, MEMWR, RWB, BEQ, JUMP, ADDIWB) SHALL go FETCH if run=1, else IDLE, and increment icnt by 1 (wraps modulo 2^ICNT_W).
REQ-024 Cycle counts from FETCH: lw 5, sw 4, R 4, beq 3, j 3, addi 4.
REQ-025 run deassertion mid-instruction SHALL NOT abort it; effective only at instruction end.
REQ-026 HALT: all strobes 0, halted=1, sticky until reset; icnt not incremented.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, icnt=0, halted=0, all strobes and pc_we 0, all selects 00, independent of clk.
REQ-028 Reset asserted mid-instruction SHALL discard it; first FETCH occurs one cycle after rst_n high with run=1.

Configuration
REQ-029 Macro MCPU_ADDI_EN defined: opcode 001000 runs ADDIEX (alu_src_a=1, alu_src_b=10, alu_op=00) then ADDIWB (reg_wr=1, reg_dst=0, mem2reg=0).
REQ-030 Macro undefined: states 11/12 absent, opcode 001000 SHALL go HALT.

Structure
REQ-031 Package mcpu_pkg SHALL hold state encodings, opcode constants, and alu_src_b/pc_src/alu_op codes.
REQ-032 One sub-module mcpu_ctrl_dec SHALL hold the combinational state-to-output decode; FSM and icnt stay in top.

Verification
REQ-033 Reset, run=1, opcode=100011 -> states 1,2,3,4,5,1; icnt=1 at the return to FETCH.
REQ-034 opcode=000100, zero=1 in BEQ -> pc_we=1, pc_src=01; zero=0 -> pc_we=0; 3 cycles each.
REQ-035 opcode=000000 with run dropped in EXEC -> RWB completes (reg_wr=1, reg_dst=1), then IDLE, icnt+1.
REQ-036 opcode=111111 -> DECODE then HALT, halted=1 held 10 cycles, icnt unchanged; rst_n pulse -> IDLE, halted=0.
REQ-037 opcode=001000 -> with MCPU_ADDI_EN states 1,2,11,12,1; without, HALT.
REQ-038 rst_n low mid-clock during MEMRD -> state=0, all outputs 0 before next edge.
